// File: rtl/channel_fifo_pkg.sv
// Shared channel definitions: default word width and depth, and the
// canonical channel word type used by HLS stages and their testbenches.
package channel_pkg;

  localparam int CHAN_WIDTH_DEFAULT = 32;
  localparam int CHAN_DEPTH_DEFAULT = 16;

  typedef logic [31:0] chan_word_t;

endpackage : channel_pkg

// File: rtl/channel_fifo_if.sv
// Channel port bundle between a producer/consumer pair and a FIFO.
// The master modport is the stage side (drives data and requests),
// the slave modport is the FIFO side (drives readiness and read data).
interface channel_fifo_if
  import channel_pkg::*;
#(
  parameter int WIDTH = CHAN_WIDTH_DEFAULT
);

  logic [WIDTH-1:0] in_data;
  logic             write_valid;
  logic             write_ready;
  logic             read_valid;
  logic             read_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_data,
    output write_valid,
    input  write_ready,
    output read_valid,
    input  read_ready,
    input  out_data
  );

  modport slave (
    input  in_data,
    input  write_valid,
    output write_ready,
    input  read_valid,
    output read_ready,
    output out_data
  );

endinterface : channel_fifo_if

// File: rtl/channel_fifo_mem.sv
// Storage array for channel_fifo: one synchronous write port and one
// asynchronous read port. Contents are never cleared by reset; the
// pointers in the parent decide which entries are meaningful.
module channel_fifo_mem #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : channel_fifo_mem

// File: rtl/channel_fifo.sv
// Single-clock FIFO channel between HLS stages.
// Registered read: a pop in cycle N shows the word on out_data in N+1 and
// it holds until the next pop. Readiness depends only on the stored count,
// so there is no combinational path from valids to readys.
// Optional build macro CHANNEL_FIFO_STATS_EN adds level, overflow and
// underflow outputs; the flags are sticky until rst or chan_rst.
module channel_fifo
  import channel_pkg::*;
#(
  parameter int  WIDTH  = CHAN_WIDTH_DEFAULT,
  parameter int  DEPTH  = CHAN_DEPTH_DEFAULT,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            chan_rst,
  channel_fifo_if.slave   ch
`ifdef CHANNEL_FIFO_STATS_EN
  ,
  output logic [ADDR_W:0] level,
  output logic            overflow,
  output logic            underflow
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ZERO_CNT = (ADDR_W+1)'(0);

  logic              eff_rst_s;
  logic              push_s;
  logic              pop_s;
  logic [WIDTH-1:0]  rdata_s;

  logic [ADDR_W-1:0] wr_ptr_q,      wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,      rd_ptr_d;
  logic [ADDR_W:0]   count_q,       count_d;
  logic [WIDTH-1:0]  out_data_q,    out_data_d;
  logic              write_ready_q, write_ready_d;
  logic              read_ready_q,  read_ready_d;

  // Either reset source clears the channel; handshakes use registered readiness.
  always_comb begin
    eff_rst_s = rst | chan_rst;
    push_s    = ch.write_valid & write_ready_q;
    pop_s     = ch.read_valid  & read_ready_q;
  end

  channel_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_s & ~eff_rst_s),
    .waddr (wr_ptr_q),
    .wdata (ch.in_data),
    .raddr (rd_ptr_q),
    .rdata (rdata_s)
  );

  // Next pointers, occupancy, readiness and read-data register contents.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    out_data_d    = out_data_q;
    count_d       = count_q;
    write_ready_d = write_ready_q;
    read_ready_d  = read_ready_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
      out_data_d = rdata_s;
    end else begin
      rd_ptr_d   = rd_ptr_q;
      out_data_d = out_data_q;
    end

    count_d       = count_q + (ADDR_W+1)'(push_s) - (ADDR_W+1)'(pop_s);
    // Readiness is a pure function of the next count, held in flops.
    write_ready_d = (count_d != FULL_CNT);
    read_ready_d  = (count_d != ZERO_CNT);
  end

  // Channel state registers; effective reset discards all queued data.
  always_ff @(posedge clk) begin
    if (eff_rst_s) begin
      wr_ptr_q      <= ADDR_W'(0);
      rd_ptr_q      <= ADDR_W'(0);
      count_q       <= ZERO_CNT;
      out_data_q    <= WIDTH'(0);
      write_ready_q <= 1'b1;
      read_ready_q  <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_data_q    <= out_data_d;
      write_ready_q <= write_ready_d;
      read_ready_q  <= read_ready_d;
    end
  end

  assign ch.write_ready = write_ready_q;
  assign ch.read_ready  = read_ready_q;
  assign ch.out_data    = out_data_q;

`ifdef CHANNEL_FIFO_STATS_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: a request against a full/empty channel sets them.
  always_comb begin
    overflow_d  = overflow_q  | (ch.write_valid & ~write_ready_q);
    underflow_d = underflow_q | (ch.read_valid  & ~read_ready_q);
  end

  // Flag registers, cleared only by effective reset.
  always_ff @(posedge clk) begin
    if (eff_rst_s) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign level     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule : channel_fifo
